// File: rtl/i2c_target_regs.sv
// I2C target at slaveAddress: register pointer byte, burst writes and sequential reads.
// Inputs are synchronised and glitch-filtered (about filterLength+3 cycles); the master sets the pace, so there is no backpressure.
module i2c_target_regs #(
    parameter logic [6:0]  slaveAddress = 7'h57,
    parameter int unsigned filterLength = 4
) (
    input  logic       refClock,
    input  logic       reset_n,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] regAddr,
    output logic [7:0] regWrData,
    output logic       regWrEn,
    input  logic [7:0] regRdData,
    output logic       busy
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ADDR   = 3'd1;
    localparam logic [2:0] ACK_A  = 3'd2;
    localparam logic [2:0] REG    = 3'd3;
    localparam logic [2:0] WDATA  = 3'd4;
    localparam logic [2:0] RD     = 3'd5;
    localparam logic [2:0] RD_ACK = 3'd6;
    localparam logic [2:0] IGNORE = 3'd7;
    localparam logic [3:0] FILT_MAX = 4'(filterLength - 1);

    logic       scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
    logic       scl_f_q, sda_f_q, scl_fd_q, sda_fd_q;
    logic [3:0] scl_cnt_q, sda_cnt_q;

    always_ff @(posedge refClock) begin
        if (!reset_n) begin
            scl_s1_q  <= 1'b1;
            scl_s2_q  <= 1'b1;
            sda_s1_q  <= 1'b1;
            sda_s2_q  <= 1'b1;
            scl_f_q   <= 1'b1;
            sda_f_q   <= 1'b1;
            scl_fd_q  <= 1'b1;
            sda_fd_q  <= 1'b1;
            scl_cnt_q <= '0;
            sda_cnt_q <= '0;
        end else begin
            scl_s1_q <= scl;
            scl_s2_q <= scl_s1_q;
            sda_s1_q <= sda;
            sda_s2_q <= sda_s1_q;
            scl_fd_q <= scl_f_q;
            sda_fd_q <= sda_f_q;
            // The count only runs while the synchronised level differs from the filtered one.
            if (scl_s2_q == scl_f_q) begin
                scl_cnt_q <= '0;
            end else if (scl_cnt_q == FILT_MAX) begin
                scl_f_q   <= scl_s2_q;
                scl_cnt_q <= '0;
            end else begin
                scl_cnt_q <= scl_cnt_q + 4'd1;
            end
            if (sda_s2_q == sda_f_q) begin
                sda_cnt_q <= '0;
            end else if (sda_cnt_q == FILT_MAX) begin
                sda_f_q   <= sda_s2_q;
                sda_cnt_q <= '0;
            end else begin
                sda_cnt_q <= sda_cnt_q + 4'd1;
            end
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  =  scl_f_q & ~scl_fd_q;
    assign scl_fall  = ~scl_f_q &  scl_fd_q;
    assign start_det =  sda_fd_q & ~sda_f_q & scl_f_q;
    assign stop_det  = ~sda_fd_q &  sda_f_q & scl_f_q;

    logic [2:0] state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic       sda_oe_q, sda_oe_d, ack_q, ack_d, rw_q, rw_d, busy_q, busy_d;
    logic [7:0] addr_q, addr_d, wr_data_q, wr_data_d;
    logic       wr_en_q, wr_en_d;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        sda_oe_d  = sda_oe_q;
        ack_d     = ack_q;
        rw_d      = rw_q;
        busy_d    = busy_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        if (wr_en_q) addr_d = addr_q + 8'd1;
        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            ack_d     = 1'b0;
        end else if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            ack_d     = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR, REG, WDATA: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = {shift_q[5:0], sda_f_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (state_q == ADDR) begin
                                if (shift_q == slaveAddress) begin
                                    state_d = ACK_A;
                                    busy_d  = 1'b1;
                                    rw_d    = sda_f_q;
                                end else begin
                                    state_d = IGNORE;
                                    busy_d  = 1'b0;
                                end
                            end else if (state_q == REG) begin
                                addr_d = {shift_q, sda_f_q};
                            end else begin
                                wr_en_d   = 1'b1;
                                wr_data_d = {shift_q, sda_f_q};
                            end
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        // First falling edge after the byte pulls ACK, the second releases it.
                        if (!ack_q) begin
                            sda_oe_d = 1'b1;
                            ack_d    = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            ack_d     = 1'b0;
                            bit_cnt_d = '0;
                            if (state_q == REG) state_d = WDATA;
                        end
                    end
                end
                ACK_A: begin
                    if (scl_fall) begin
                        if (!ack_q) begin
                            sda_oe_d = 1'b1;
                            ack_d    = 1'b1;
                        end else if (rw_q) begin
                            ack_d     = 1'b0;
                            state_d   = RD;
                            shift_d   = regRdData[6:0];
                            sda_oe_d  = ~regRdData[7];
                            bit_cnt_d = 4'd1;
                        end else begin
                            ack_d     = 1'b0;
                            state_d   = REG;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                        end
                    end
                end
                RD: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            ack_d    = 1'b0;
                            state_d  = RD_ACK;
                        end else begin
                            sda_oe_d  = ~shift_q[6];
                            shift_d   = {shift_q[5:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_f_q) begin
                            addr_d = addr_q + 8'd1;
                            ack_d  = 1'b1;
                        end else begin
                            state_d = IGNORE;
                        end
                    end else if (scl_fall && ack_q) begin
                        ack_d     = 1'b0;
                        state_d   = RD;
                        shift_d   = regRdData[6:0];
                        sda_oe_d  = ~regRdData[7];
                        bit_cnt_d = 4'd1;
                    end
                end
                IGNORE:  sda_oe_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge refClock) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            sda_oe_q  <= 1'b0;
            ack_q     <= 1'b0;
            rw_q      <= 1'b0;
            busy_q    <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            sda_oe_q  <= sda_oe_d;
            ack_q     <= ack_d;
            rw_q      <= rw_d;
            busy_q    <= busy_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
        end
    end

    assign sda       = sda_oe_q ? 1'b0 : 1'bz;
    assign regAddr   = addr_q;
    assign regWrData = wr_data_q;
    assign regWrEn   = wr_en_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a bit-level I2C master, a register-file model and a write scoreboard.
module tb_i2c_target_regs;
    localparam logic [6:0] SLV = 7'h57;
    localparam int H  = 16;
    localparam int GL = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       m_sda_low = 1'b0;
    wire        sda_w;
    logic [7:0] reg_addr, reg_wr_data, rd_data;
    logic       reg_wr_en, busy;

    pullup (sda_w);
    assign sda_w = m_sda_low ? 1'b0 : 1'bz;

    logic [7:0]  mem [256];
    logic [7:0]  mdl_ptr = 8'h00;
    logic [15:0] exp_wr[$];
    logic [7:0]  frame[$];
    logic        prev_wr = 1'b0;
    bit          glitch_on = 1'b0;
    int          total = 0;
    int          bad = 0;

    assign rd_data = mem[reg_addr];

    i2c_target_regs #(.slaveAddress(SLV), .filterLength(4)) dut (
        .refClock(clk), .reset_n(reset_n), .scl(scl_m), .sda(sda_w),
        .regAddr(reg_addr), .regWrData(reg_wr_data), .regWrEn(reg_wr_en),
        .regRdData(rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Every write strobe must match the next expected (addr,data) pair and last one cycle.
    always @(negedge clk) begin
        if (reset_n && reg_wr_en) begin
            chk("wr_single_cycle", prev_wr, 1'b0);
            if (exp_wr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=%h data=%h want none", reg_addr, reg_wr_data);
            end else begin
                logic [15:0] e;
                e = exp_wr.pop_front();
                chk("wr_addr", reg_addr, e[15:8]);
                chk("wr_data", reg_wr_data, e[7:0]);
            end
        end
        prev_wr = reset_n & reg_wr_en;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_io(input logic b, output logic s);
        tick(H/2);
        m_sda_low = !b;
        if (glitch_on) begin
            tick(2); scl_m = 1'b1; tick(GL); scl_m = 1'b0; tick(H/2-2-GL);
        end else tick(H/2);
        scl_m = 1'b1;
        if (glitch_on) begin
            tick(2); m_sda_low = b; tick(GL); m_sda_low = !b; tick(H/2-2-GL);
        end else tick(H/2);
        s = sda_w;
        tick(H/2);
        scl_m = 1'b0;
    endtask

    task automatic bus_start();
        tick(H/2); m_sda_low = 1'b0;
        tick(H/2); scl_m = 1'b1;
        tick(H);   m_sda_low = 1'b1;
        tick(H);   scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        tick(H/2); m_sda_low = 1'b1;
        tick(H/2); scl_m = 1'b1;
        tick(H);   m_sda_low = 1'b0;
        tick(H);
    endtask

    task automatic wr_byte(input string nm, input logic [7:0] b, input bit exp_ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_io(b[i], s);
        bit_io(1'b1, s);
        chk(nm, s, exp_ack ? 1'b0 : 1'b1);
    endtask

    task automatic rd_byte(input bit ack, output logic [7:0] v);
        logic s;
        v = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_io(1'b1, s);
            v = {v[6:0], s};
        end
        bit_io(!ack, s);
    endtask

    // First frame byte is the pointer, the rest are data written at successive addresses.
    task automatic wr_frame(input logic [7:0] ab);
        bit match;
        match = (ab[7:1] == SLV) && !ab[0];
        bus_start();
        wr_byte("addr_ack", ab, match);
        chk("busy_addressed", busy, match);
        for (int i = 0; i < frame.size(); i++) begin
            if (match) begin
                if (i == 0) mdl_ptr = frame[i];
                else begin
                    exp_wr.push_back({mdl_ptr, frame[i]});
                    mdl_ptr = mdl_ptr + 8'd1;
                end
            end
            wr_byte("data_ack", frame[i], match);
        end
        bus_stop();
        tick(4);
        chk("wr_queue_drained", exp_wr.size(), 0);
        chk("ptr_after_frame", reg_addr, mdl_ptr);
        chk("busy_after_stop", busy, 1'b0);
    endtask

    initial begin
        logic [7:0] rb, ab;
        logic s;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        tick(3);
        chk("rst_addr", reg_addr, 8'h00);
        chk("rst_wdata", reg_wr_data, 8'h00);
        chk("rst_wen", reg_wr_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sda", sda_w, 1'b1);
        reset_n = 1'b1;
        tick(10);

        frame.delete(); frame.push_back(8'h10); frame.push_back(8'hAF);
        wr_frame(8'hAE);
        chk("t1_ptr_lit", reg_addr, 8'h11);

        frame.delete(); frame.push_back(8'h33); frame.push_back(8'h44);
        wr_frame(8'hA0);
        chk("t2_ptr_unchanged", reg_addr, 8'h11);

        frame.delete(); frame.push_back(8'hFE); frame.push_back(8'h01);
        frame.push_back(8'h02); frame.push_back(8'h03);
        wr_frame(8'hAE);
        chk("t3_ptr_lit", reg_addr, 8'h01);

        mem[8'h20] = 8'h5A;
        mem[8'h21] = 8'hC3;
        bus_start();
        wr_byte("rd_addr_w", 8'hAE, 1'b1);
        wr_byte("rd_ptr", 8'h20, 1'b1);
        mdl_ptr = 8'h20;
        bus_start();
        wr_byte("rd_addr_r", 8'hAF, 1'b1);
        rd_byte(1'b1, rb);
        chk("rd0_model", rb, mem[mdl_ptr]);
        chk("rd0_lit", rb, 8'h5A);
        mdl_ptr = mdl_ptr + 8'd1;
        rd_byte(1'b0, rb);
        chk("rd1_model", rb, mem[mdl_ptr]);
        chk("rd1_lit", rb, 8'hC3);
        tick(H/2);
        chk("rd_nack_release", sda_w, 1'b1);
        bus_stop();
        tick(4);
        chk("rd_ptr_model", reg_addr, mdl_ptr);
        chk("rd_ptr_lit", reg_addr, 8'h21);
        chk("rd_busy_after_stop", busy, 1'b0);
        chk("rd_no_writes", exp_wr.size(), 0);

        bus_start();
        ab = 8'hAE;
        for (int i = 7; i >= 0; i--) bit_io(ab[i], s);
        tick(H/2);
        m_sda_low = 1'b0;
        chk("rst_ack_held", sda_w, 1'b0);
        chk("rst_busy_before", busy, 1'b1);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        chk("rst_mid_sda", sda_w, 1'b1);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_addr", reg_addr, 8'h00);
        tick(H/2); scl_m = 1'b1;
        tick(H);   scl_m = 1'b0;
        bus_stop();
        tick(10);
        frame.delete(); frame.push_back(8'h30); frame.push_back(8'h77);
        wr_frame(8'hAE);
        chk("rst_after_ptr_lit", reg_addr, 8'h31);

        m_sda_low = 1'b1; tick(GL); m_sda_low = 1'b0; tick(20);
        scl_m = 1'b0; tick(GL); scl_m = 1'b1; tick(20);
        chk("idle_glitch_busy", busy, 1'b0);
        glitch_on = 1'b1;
        frame.delete(); frame.push_back(8'h40); frame.push_back(8'h96); frame.push_back(8'h69);
        wr_frame(8'hAE);
        glitch_on = 1'b0;
        chk("glitch_ptr_lit", reg_addr, 8'h42);

        tick(20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
